// File: rtl/noc_pkg.sv
// Shared NoC definitions: default field widths, flit field offsets, injector FSM states.
package noc_pkg;

  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned COORD_X_W = 2;
  localparam int unsigned COORD_Y_W = 2;

  // Destination {x,y} occupies the low bits of every flit.
  localparam int unsigned DST_LSB = 0;

  function automatic int unsigned src_y_lsb(input int unsigned xs, input int unsigned ys);
    return xs + ys;
  endfunction

  function automatic int unsigned src_x_lsb(input int unsigned xs, input int unsigned ys);
    return xs + 2 * ys;
  endfunction

  function automatic int unsigned payload_lsb(input int unsigned xs, input int unsigned ys);
    return 2 * xs + 2 * ys;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head and head+1 read ports so a consumer can chain entries.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           rd_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign rd_data    = mem[rd_ptr];
  assign rd_next    = mem[rd_ptr_inc];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_injector.sv
// PE injector: buffers neuron payloads and fans each one out as NUM_DEST flits to the switch.
module pe_injector
  import noc_pkg::*;
#(
  parameter int X_COORD     = 2,
  parameter int Y_COORD     = 0,
  parameter int DATA_WIDTH  = PAYLOAD_W,
  parameter int X_SIZE      = COORD_X_W,
  parameter int Y_SIZE      = COORD_Y_W,
  parameter int TOTAL_WIDTH = 2 * X_SIZE + 2 * Y_SIZE + DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_DEST    = 2,
  parameter logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] DEST_MAP = {2'd3, 2'd0, 2'd2, 2'd1}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [TOTAL_WIDTH-1:0]        o_data_sw,
  output logic                          o_valid_sw,
  input  logic                          i_ready_sw,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned COORD_W = X_SIZE + Y_SIZE;
  localparam int unsigned IDX_W   = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int unsigned SRC_Y_L = src_y_lsb(X_SIZE, Y_SIZE);
  localparam int unsigned SRC_X_L = src_x_lsb(X_SIZE, Y_SIZE);
  localparam int unsigned PAY_L   = payload_lsb(X_SIZE, Y_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEST - 1);

  inj_state_t              state_q, state_n;
  logic [IDX_W-1:0]        idx_q, idx_n, idx_inc;
  logic [TOTAL_WIDTH-1:0]  data_q, data_n;
  logic                    valid_q, valid_n;
  logic [DATA_WIDTH-1:0]   head, head_next;
  logic                    full, empty, push, pop;

  function automatic logic [TOTAL_WIDTH-1:0] make_flit(input logic [DATA_WIDTH-1:0] payload,
                                                       input logic [IDX_W-1:0]      idx);
    logic [TOTAL_WIDTH-1:0] f;
    f = '0;
    f[DST_LSB +: COORD_W] = DEST_MAP[int'(idx) * COORD_W +: COORD_W];
    f[SRC_Y_L +: Y_SIZE]  = Y_SIZE'(Y_COORD);
    f[SRC_X_L +: X_SIZE]  = X_SIZE'(X_COORD);
    f[PAY_L +: DATA_WIDTH] = payload;
    return f;
  endfunction

  assign in_ready   = ~full;
  assign push       = in_valid & ~full;
  assign o_data_sw  = data_q;
  assign o_valid_sw = valid_q;
  assign busy       = (state_q != IDLE) | ~empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .rd_next (head_next),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // State, destination index and registered flit output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      valid_q <= valid_n;
    end
  end

  // Next-state and flit selection. The head payload stays in the FIFO until its last
  // flit is accepted; rd_next lets the following payload start without a bubble.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    data_n  = data_q;
    valid_n = valid_q;
    pop     = 1'b0;
    idx_inc = idx_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          data_n  = make_flit(head, '0);
          valid_n = 1'b1;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (valid_q && i_ready_sw) begin
          if (idx_q != LAST_IDX) begin
            idx_n  = idx_inc;
            data_n = make_flit(head, idx_inc);
          end else begin
            pop   = 1'b1;
            idx_n = '0;
            if (fifo_count > CW'(1)) begin
              data_n = make_flit(head_next, '0);
            end else begin
              valid_n = 1'b0;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_injector.sv
// Directed bench for pe_injector: default two-destination instance plus a single-destination one.
module tb_pe_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o_data_sw;
  logic        o_valid_sw;
  logic        i_ready_sw;
  logic [2:0]  fifo_count;
  logic        busy;

  logic [7:0]  in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] o_data_sw1;
  logic        o_valid_sw1;
  logic        i_ready_sw1;
  logic [2:0]  fifo_count1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_injector dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .o_data_sw  (o_data_sw),
    .o_valid_sw (o_valid_sw),
    .i_ready_sw (i_ready_sw),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  pe_injector #(
    .NUM_DEST (1),
    .DEST_MAP (4'b1000)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .o_data_sw  (o_data_sw1),
    .o_valid_sw (o_valid_sw1),
    .i_ready_sw (i_ready_sw1),
    .fifo_count (fifo_count1),
    .busy       (busy1)
  );

  typedef struct {
    logic [7:0]  din;
    logic        vin;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  ec;
    logic        er;
    logic        eb;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_flit;
    logic [15:0] drain [5];

    tbl[0]  = '{8'h5A, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 16'h5A89, 3'd1, 1'b1, 1'b1};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 16'h5A8C, 3'd1, 1'b1, 1'b1};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b1, 1'b1};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 16'h3C89, 3'd1, 1'b1, 1'b1};
    for (int unsigned i = 6; i <= 10; i++)
      tbl[i] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'h3C89, 3'd1, 1'b1, 1'b1};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b1, 16'h3C8C, 3'd1, 1'b1, 1'b1};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; i_ready_sw = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; i_ready_sw1 = 1'b1;
    tick(); tick();
    check("rst_valid", o_valid_sw, 0);
    check("rst_data",  o_data_sw, 16'h0000);
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy",  busy, 0);
    rst = 1'b0;

    // Single payload fan-out, then the same with a five-cycle stall on the first flit.
    for (int unsigned i = 0; i < 13; i++) begin
      in_data = tbl[i].din; in_valid = tbl[i].vin; i_ready_sw = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), o_valid_sw, tbl[i].ev);
      if (tbl[i].ev) check($sformatf("tbl%0d_data", i), o_data_sw, tbl[i].ed);
      check($sformatf("tbl%0d_count", i), fifo_count, tbl[i].ec);
      check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
    end
    in_valid = 1'b0;

    // Fill the FIFO under backpressure, overflow attempt, then bubble-free drain.
    i_ready_sw = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      in_data = 8'(8'hA1 + k); in_valid = 1'b1;
      tick();
      check($sformatf("fill%0d_count", k), fifo_count, k + 1);
    end
    check("full_ready", in_ready, 0);
    check("full_head", o_data_sw, 16'hA189);
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    check("overflow_count", fifo_count, 4);
    in_valid = 1'b0; i_ready_sw = 1'b1;
    for (int unsigned j = 0; j < 8; j++) begin
      exp_flit = {8'(8'hA1 + j / 2), (j % 2 == 1) ? 8'h8C : 8'h89};
      check($sformatf("drain%0d_valid", j), o_valid_sw, 1);
      check($sformatf("drain%0d_data", j), o_data_sw, exp_flit);
      tick();
    end
    check("drain_end_valid", o_valid_sw, 0);
    check("drain_end_count", fifo_count, 0);

    // Push coinciding with the final-flit pop at occupancy 3.
    i_ready_sw = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      in_data = 8'(8'hB1 + k); in_valid = 1'b1;
      tick();
    end
    check("b3_count", fifo_count, 3);
    check("b3_data", o_data_sw, 16'hB189);
    in_valid = 1'b0; i_ready_sw = 1'b1;
    tick();
    check("b_idx1_data", o_data_sw, 16'hB18C);
    in_data = 8'hB4; in_valid = 1'b1;
    tick();
    check("pushpop_count", fifo_count, 3);
    check("pushpop_data", o_data_sw, 16'hB289);
    in_valid = 1'b0;
    drain[0] = 16'hB28C; drain[1] = 16'hB389; drain[2] = 16'hB38C;
    drain[3] = 16'hB489; drain[4] = 16'hB48C;
    for (int unsigned j = 0; j < 5; j++) begin
      tick();
      check($sformatf("b_drain%0d_valid", j), o_valid_sw, 1);
      check($sformatf("b_drain%0d_data", j), o_data_sw, drain[j]);
    end
    tick();
    check("b_end_valid", o_valid_sw, 0);
    check("b_end_count", fifo_count, 0);

    // Reset in the middle of a fan-out with two payloads buffered.
    i_ready_sw = 1'b0;
    in_data = 8'hC1; in_valid = 1'b1; tick();
    in_data = 8'hC2; in_valid = 1'b1; tick();
    in_valid = 1'b0; i_ready_sw = 1'b1; tick();
    check("c_idx1_data", o_data_sw, 16'hC18C);
    check("c_count", fifo_count, 2);
    i_ready_sw = 1'b0; rst = 1'b1; tick();
    check("midrst_valid", o_valid_sw, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_busy",  busy, 0);
    rst = 1'b0; i_ready_sw = 1'b1;
    tick(); tick(); tick();
    check("postrst_valid", o_valid_sw, 0);
    check("postrst_count", fifo_count, 0);

    // Single-destination instance addressed at its own coordinates.
    in_data1 = 8'h11; in_valid1 = 1'b1; tick();
    check("nd1_first_valid", o_valid_sw1, 0);
    check("nd1_first_count", fifo_count1, 1);
    in_data1 = 8'h11; tick();
    check("nd1_f0_valid", o_valid_sw1, 1);
    check("nd1_f0_data", o_data_sw1, 16'h1188);
    in_data1 = 8'h22; tick();
    check("nd1_f1_valid", o_valid_sw1, 1);
    check("nd1_f1_data", o_data_sw1, 16'h1188);
    in_valid1 = 1'b0; tick();
    check("nd1_f2_valid", o_valid_sw1, 1);
    check("nd1_f2_data", o_data_sw1, 16'h2288);
    tick();
    check("nd1_end_valid", o_valid_sw1, 0);
    check("nd1_end_count", fifo_count1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
